// File: rtl/wr_uart_line_monitor_if.sv
// Bridge master port of the UART line monitor: one strobe-held read/write
// transaction at a time, completed by the slave's acknowledge.
interface wr_uart_line_monitor_if #(
  parameter int ADDR_W = 6
);
  logic              bridge_uart_read;
  logic              bridge_uart_write;
  logic [3:0]        bridge_uart_byte_enable;
  logic [ADDR_W-1:0] bridge_uart_address;
  logic [31:0]       bridge_uart_write_data;
  logic [31:0]       bridge_uart_read_data;
  logic              bridge_uart_acknowledge;

  modport master (
    output bridge_uart_read, bridge_uart_write, bridge_uart_byte_enable,
           bridge_uart_address, bridge_uart_write_data,
    input  bridge_uart_read_data, bridge_uart_acknowledge
  );

  modport slave (
    input  bridge_uart_read, bridge_uart_write, bridge_uart_byte_enable,
           bridge_uart_address, bridge_uart_write_data,
    output bridge_uart_read_data, bridge_uart_acknowledge
  );
endinterface

// File: rtl/wr_uart_line_monitor.sv
// Polls a UART through the bridge, collects characters into a line buffer and
// streams each completed line out with last/overflow qualifiers.
module wr_uart_line_monitor #(
  parameter int                ADDR_W       = 6,
  parameter logic [ADDR_W-1:0] STATUS_ADDR  = 'h0,
  parameter logic [ADDR_W-1:0] RXDATA_ADDR  = 'h1,
  parameter logic [ADDR_W-1:0] CTRL_ADDR    = 'h2,
  parameter logic [31:0]       CTRL_INIT    = 32'h0000_0000,
  parameter int                RX_READY_BIT = 7,
  parameter int                LINE_DEPTH   = 64,
  parameter logic [7:0]        TERMINATOR   = 8'h0A,
  parameter bit                STRIP_CR     = 1'b1,
  parameter int                ACK_TIMEOUT  = 255,
  parameter int                POLL_GAP     = 4
) (
  input  logic                   clock,
  input  logic                   nreset,
  wr_uart_line_monitor_if.master bridge,
  output logic [7:0]             line_data,
  output logic                   line_valid,
  output logic                   line_last,
  output logic                   line_overflow,
  input  logic                   line_ready,
  output logic                   bus_error
);
  localparam int IDX_W = $clog2(LINE_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {RST_RD, INIT_WR, GAP, POLL_RD, DATA_RD, DRAIN} state_t;

  state_t            state;
  logic              rd, wr;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [TMR_W-1:0]  timer;
  logic [GAP_W-1:0]  gap_cnt;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        mem [LINE_DEPTH];

  logic [7:0]        rx_char;
  logic              is_term, is_cr, has_room, data_ack, store_en, nxt_last;
  logic [ADDR_W-1:0] bus_addr;
  logic              unused_rdata;

  assign bridge.bridge_uart_read        = rd;
  assign bridge.bridge_uart_write       = wr;
  assign bridge.bridge_uart_byte_enable = be;
  assign bridge.bridge_uart_address     = addr;
  assign bridge.bridge_uart_write_data  = wdata;

  assign unused_rdata = ^bridge.bridge_uart_read_data;
  assign rx_char  = bridge.bridge_uart_read_data[7:0];
  assign is_term  = (rx_char == TERMINATOR);
  assign is_cr    = STRIP_CR && (rx_char == 8'h0D);
  assign has_room = (count < CNT_W'(LINE_DEPTH));
  assign data_ack = (state == DATA_RD) && rd && bridge.bridge_uart_acknowledge;
  assign store_en = data_ack && !is_term && !is_cr && has_room;
  assign nxt_last = ((CNT_W'(idx) + CNT_W'(2)) == count);

  always_comb begin
    bus_addr = STATUS_ADDR;
    case (state)
      INIT_WR: bus_addr = CTRL_ADDR;
      DATA_RD: bus_addr = RXDATA_ADDR;
      default: ;
    endcase
  end

  // Line storage carries no reset: count alone decides what is valid.
  always_ff @(posedge clock)
    if (store_en) mem[count[IDX_W-1:0]] <= rx_char;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state         <= RST_RD;
      rd            <= 1'b0;
      wr            <= 1'b0;
      be            <= 4'h0;
      addr          <= '0;
      wdata         <= '0;
      timer         <= '0;
      gap_cnt       <= '0;
      count         <= '0;
      ovf           <= 1'b0;
      idx           <= '0;
      line_data     <= '0;
      line_valid    <= 1'b0;
      line_last     <= 1'b0;
      line_overflow <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      bus_error <= 1'b0;
      case (state)
        RST_RD, INIT_WR, POLL_RD, DATA_RD: begin
          if (!(rd || wr)) begin
            // Entry cycle runs with strobes low, so back-to-back
            // transactions are always separated by an idle cycle.
            rd    <= (state != INIT_WR);
            wr    <= (state == INIT_WR);
            be    <= 4'hF;
            addr  <= bus_addr;
            wdata <= (state == INIT_WR) ? CTRL_INIT : 32'h0;
            timer <= '0;
          end else if (bridge.bridge_uart_acknowledge) begin
            rd      <= 1'b0;
            wr      <= 1'b0;
            be      <= 4'h0;
            wdata   <= '0;
            gap_cnt <= '0;
            case (state)
              RST_RD:  state <= INIT_WR;
              INIT_WR: state <= GAP;
              POLL_RD: state <= bridge.bridge_uart_read_data[RX_READY_BIT] ? DATA_RD : GAP;
              default: begin
                if (is_term) state <= (count != '0) ? DRAIN : GAP;
                else begin
                  state <= GAP;
                  if (!is_cr) begin
                    if (has_room) count <= count + CNT_W'(1);
                    else          ovf   <= 1'b1;
                  end
                end
              end
            endcase
          end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
            rd        <= 1'b0;
            wr        <= 1'b0;
            be        <= 4'h0;
            wdata     <= '0;
            bus_error <= 1'b1;
            gap_cnt   <= '0;
            state     <= GAP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        GAP: begin
          // The poll strobe is raised as GAP ends so the idle run is POLL_GAP.
          if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
            state <= POLL_RD;
            rd    <= 1'b1;
            be    <= 4'hF;
            addr  <= STATUS_ADDR;
            timer <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        DRAIN: begin
          if (!line_valid) begin
            line_valid    <= 1'b1;
            line_data     <= mem[0];
            line_last     <= (count == CNT_W'(1));
            line_overflow <= ovf && (count == CNT_W'(1));
            idx           <= '0;
          end else if (line_ready) begin
            if (line_last) begin
              line_valid    <= 1'b0;
              line_last     <= 1'b0;
              line_overflow <= 1'b0;
              count         <= '0;
              ovf           <= 1'b0;
              gap_cnt       <= '0;
              state         <= GAP;
            end else begin
              idx           <= idx + IDX_W'(1);
              line_data     <= mem[idx + IDX_W'(1)];
              line_last     <= nxt_last;
              line_overflow <= ovf && nxt_last;
            end
          end
        end
        default: state <= RST_RD;
      endcase
    end
  end
endmodule

// File: tb/tb_wr_uart_line_monitor.sv
// Bench for wr_uart_line_monitor: scripted bridge slave plus a line model
// whose expected stream beats are queued and popped as the DUT emits them.
module tb_wr_uart_line_monitor;
  localparam int          ADDR_W     = 6;
  localparam logic [5:0]  ST_A       = 6'h00;
  localparam logic [5:0]  RX_A       = 6'h01;
  localparam logic [5:0]  CT_A       = 6'h02;
  localparam logic [31:0] CT_INIT    = 32'hA5A5_0003;
  localparam int          DEPTH      = 4;
  localparam int          TMO        = 20;
  localparam int          PGAP       = 4;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       ovf;
  } beat_t;

  logic       clock = 1'b0;
  logic       nreset = 1'b0;
  logic       line_ready = 1'b1;
  logic [7:0] line_data;
  logic       line_valid, line_last, line_overflow, bus_error;

  int checks = 0, failures = 0;
  int beats_seen = 0, drain_bus = 0, last_gap = 0;

  beat_t      exp_q[$];
  logic [7:0] line_m[$];
  bit         ovf_m = 1'b0;

  wr_uart_line_monitor_if #(.ADDR_W(ADDR_W)) bus ();

  wr_uart_line_monitor #(
    .ADDR_W(ADDR_W), .STATUS_ADDR(ST_A), .RXDATA_ADDR(RX_A), .CTRL_ADDR(CT_A),
    .CTRL_INIT(CT_INIT), .RX_READY_BIT(7), .LINE_DEPTH(DEPTH), .TERMINATOR(8'h0A),
    .STRIP_CR(1'b1), .ACK_TIMEOUT(TMO), .POLL_GAP(PGAP)
  ) dut (
    .clock(clock), .nreset(nreset), .bridge(bus),
    .line_data(line_data), .line_valid(line_valid), .line_last(line_last),
    .line_overflow(line_overflow), .line_ready(line_ready), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted beat must match the oldest queued expectation.
  always @(negedge clock) begin
    if (nreset && line_valid && line_ready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", {24'h0, line_data}, 32'hFFFF_FFFF);
      else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_data", {24'h0, line_data}, {24'h0, e.d});
        chk("beat_last", {31'h0, line_last}, {31'h0, e.last});
        chk("beat_ovf", {31'h0, line_overflow}, {31'h0, e.ovf});
        beats_seen++;
      end
    end
    if (line_valid && (bus.bridge_uart_read || bus.bridge_uart_write)) drain_bus++;
  end

  task automatic model_char(input logic [7:0] c);
    if (c == 8'h0A) begin
      for (int i = 0; i < line_m.size(); i++)
        exp_q.push_back('{d: line_m[i], last: (i == line_m.size() - 1),
                          ovf: ovf_m && (i == line_m.size() - 1)});
      line_m.delete();
      ovf_m = 1'b0;
    end else if (c != 8'h0D) begin
      if (line_m.size() < DEPTH) line_m.push_back(c);
      else ovf_m = 1'b1;
    end
  endtask

  // Waits for a strobe, checks it, acknowledges after dly cycles.
  task automatic bus_xact(input string tag, input bit exp_wr, input logic [5:0] exp_addr,
                          input logic [31:0] rdata, input int exp_gap, input int dly);
    int n = 0;
    while (!(bus.bridge_uart_read || bus.bridge_uart_write) && n < 200) begin
      @(negedge clock);
      n++;
    end
    last_gap = n;
    if (n >= 200) begin
      chk({tag, "_no_strobe"}, 32'h0, 32'h1);
      return;
    end
    if (exp_gap >= 0) chk({tag, "_gap"}, n, exp_gap);
    for (int i = 0; i < dly; i++) begin
      @(negedge clock);
      chk({tag, "_hold_addr"}, {26'h0, bus.bridge_uart_address}, {26'h0, exp_addr});
    end
    chk({tag, "_rd"}, {31'h0, bus.bridge_uart_read}, {31'h0, !exp_wr});
    chk({tag, "_wr"}, {31'h0, bus.bridge_uart_write}, {31'h0, exp_wr});
    chk({tag, "_addr"}, {26'h0, bus.bridge_uart_address}, {26'h0, exp_addr});
    chk({tag, "_be"}, {28'h0, bus.bridge_uart_byte_enable}, 32'hF);
    if (exp_wr) chk({tag, "_wdata"}, bus.bridge_uart_write_data, CT_INIT);
    bus.bridge_uart_read_data   = rdata;
    bus.bridge_uart_acknowledge = 1'b1;
    @(negedge clock);
    bus.bridge_uart_acknowledge = 1'b0;
    bus.bridge_uart_read_data   = 32'h0;
    chk({tag, "_drop"}, {31'h0, bus.bridge_uart_read || bus.bridge_uart_write}, 32'h0);
  endtask

  task automatic send_char(input logic [7:0] c);
    bus_xact("poll_rdy", 1'b0, ST_A, 32'hFFFF_FF80, -1, 0);
    model_char(c);
    bus_xact("data", 1'b0, RX_A, {24'hC3D2E1, c}, 1, 0);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_init();
    bus_xact("rst_rd", 1'b0, ST_A, 32'h168, -1, 0);
    bus_xact("init_wr", 1'b1, CT_A, 32'h0, 1, 3);
  endtask

  initial begin
    bus.bridge_uart_read_data   = 32'h0;
    bus.bridge_uart_acknowledge = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_strobes", {30'h0, bus.bridge_uart_read, bus.bridge_uart_write}, 32'h0);
    chk("rst_be", {28'h0, bus.bridge_uart_byte_enable}, 32'h0);
    chk("rst_addr", {26'h0, bus.bridge_uart_address}, 32'h0);
    chk("rst_wdata", bus.bridge_uart_write_data, 32'h0);
    chk("rst_stream", {29'h0, line_valid, line_last, line_overflow}, 32'h0);
    chk("rst_err", {31'h0, bus_error}, 32'h0);
    nreset = 1'b1;
    do_init();

    for (int i = 0; i < 3; i++) bus_xact("poll_idle", 1'b0, ST_A, 32'h0000_007F, PGAP, 0);

    send_str("gui\n");
    wait_drain();
    send_str("abcdef\n");
    wait_drain();
    send_str("xy\n");
    wait_drain();
    send_str("ok\r\n");
    wait_drain();
    send_str("\n");
    for (int i = 0; i < 2; i++) bus_xact("poll_after_nl", 1'b0, ST_A, 32'h0, PGAP, 0);

    // Withheld acknowledge on a poll.
    begin
      int hi = 0;
      while (!bus.bridge_uart_read && hi < 200) begin @(negedge clock); hi++; end
      hi = 0;
      while (bus.bridge_uart_read && hi < 200) begin
        chk("tmo_err_early", {31'h0, bus_error}, 32'h0);
        @(negedge clock);
        hi++;
      end
      chk("tmo_len", hi, TMO);
      chk("tmo_err", {31'h0, bus_error}, 32'h1);
      @(negedge clock);
      chk("tmo_err_pulse", {31'h0, bus_error}, 32'h0);
      bus_xact("poll_resume", 1'b0, ST_A, 32'h0, PGAP - 1, 0);
    end

    // Downstream stall during DRAIN.
    line_ready = 1'b0;
    send_str("hi\n");
    begin
      int n = 0;
      while (!line_valid && n < 20) begin @(negedge clock); n++; end
      chk("stall_valid", {31'h0, line_valid}, 32'h1);
      for (int i = 0; i < 8; i++) begin
        @(negedge clock);
        chk("stall_data", {24'h0, line_data}, 32'h68);
        chk("stall_ctl", {30'h0, line_valid, line_last}, 32'h2);
      end
    end
    line_ready = 1'b1;
    wait_drain();

    // Reset during a pending transaction discards the partial line.
    send_char("q");
    begin
      int n = 0;
      while (!bus.bridge_uart_read && n < 200) begin @(negedge clock); n++; end
      nreset = 1'b0;
      #1;
      chk("midrst_strobe", {31'h0, bus.bridge_uart_read}, 32'h0);
      chk("midrst_be", {28'h0, bus.bridge_uart_byte_enable}, 32'h0);
      line_m.delete();
      ovf_m = 1'b0;
      @(negedge clock);
      nreset = 1'b1;
    end
    do_init();
    send_str("z\n");
    wait_drain();
    repeat (10) @(negedge clock);

    chk("beats_total", beats_seen, 14);
    chk("exp_left", exp_q.size(), 0);
    chk("bus_in_drain", drain_bus, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end
endmodule
